// File: rtl/branch_resolve_pkg.sv
// Shared types for branch resolution: sequence numbers, branch/BTB payloads, FSM state.
package branch_resolve_pkg;

  localparam int unsigned SQN_W                   = 6;
  localparam int unsigned PC_W                    = 32;
  localparam int unsigned RECOVERY_CYCLES_DEFAULT = 2;

  typedef logic [SQN_W-1:0] SqN;

  typedef struct packed {
    logic [PC_W-1:0] dstPC;
    SqN              sqN;
    logic            taken;
  } BranchProv;

  typedef struct packed {
    logic [PC_W-1:0] src;
    logic [PC_W-1:0] dst;
    logic            isJump;
    logic            valid;
  } BTUpdate;

  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } br_state_e;

  // Wrap-safe age compare: a is strictly older than b when (a - b) is negative.
  function automatic logic sqn_older(SqN a, SqN b);
    SqN d;
    d = a - b;
    return d[SQN_W-1];
  endfunction

endpackage

// File: rtl/branch_resolve_btu_fifo.sv
// Multi-push, single-pop BTB update queue with saturating drop counter.
module BTUFifo
  import branch_resolve_pkg::*;
#(
  parameter int unsigned NUM_PUSH = 2,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  BTUpdate     push_data [NUM_PUSH],
  input  logic        stall,
  output BTUpdate     head_c,
  output logic [15:0] drop_cnt
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DROP_W = $clog2(NUM_PUSH + 1);

  BTUpdate             mem [DEPTH];
  logic [PTR_W-1:0]    rptr;
  logic [PTR_W-1:0]    wptr;
  logic [CNT_W-1:0]    count;
  logic                pop;
  logic [CNT_W-1:0]    free;
  logic [CNT_W-1:0]    n_push;
  logic [DROP_W-1:0]   n_drop;
  logic [NUM_PUSH-1:0] accept;
  logic [PTR_W-1:0]    offset [NUM_PUSH];
  logic [16:0]         drop_sum;

  // Accept valid pushes in index order until free slots run out; the rest are dropped.
  always_comb begin
    pop    = (count != '0) && !stall;
    free   = CNT_W'(DEPTH) - count + CNT_W'(pop);
    n_push = '0;
    n_drop = '0;
    accept = '0;
    for (int i = 0; i < NUM_PUSH; i++) begin
      offset[i] = PTR_W'(n_push);
      if (push_data[i].valid) begin
        if (n_push < free) begin
          accept[i] = 1'b1;
          n_push    = n_push + CNT_W'(1);
        end else begin
          n_drop = n_drop + DROP_W'(1);
        end
      end
    end
    drop_sum = 17'(drop_cnt) + 17'(n_drop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_PUSH; i++) begin
        if (accept[i]) mem[wptr + offset[i]] <= push_data[i];
      end
      rptr     <= rptr + PTR_W'(pop);
      wptr     <= wptr + PTR_W'(n_push);
      count    <= count + n_push - CNT_W'(pop);
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  always_comb begin
    head_c       = mem[rptr];
    head_c.valid = (count != '0);
  end

endmodule

// File: rtl/branch_resolve.sv
// Oldest-taken-branch flush selection with post-flush recovery window and BTB update queue.
// Optional misprediction counter enabled by BRANCH_RESOLVE_MISPRED_CNT_EN.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int unsigned NUM_BRANCH_PROVS = 2,
  parameter int unsigned BTU_FIFO_DEPTH   = 4,
  parameter int unsigned RECOVERY_CYCLES  = RECOVERY_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  BranchProv   IN_branches  [NUM_BRANCH_PROVS],
  input  BTUpdate     IN_btUpdates [NUM_BRANCH_PROVS],
  input  logic        IN_btStall,
  output BranchProv   OUT_branch,
  output BTUpdate     OUT_btUpdate,
  output logic [15:0] OUT_btDropCnt
`ifdef BRANCH_RESOLVE_MISPRED_CNT_EN
  ,
  output logic [31:0] OUT_mispredCnt
`endif
);

  localparam int unsigned REC_W = $clog2(RECOVERY_CYCLES) + 1;

  br_state_e        state;
  SqN               flush_sqn;
  logic [REC_W-1:0] rec_cnt;
  BranchProv        winner;
  logic             found;

  // Oldest non-suppressed taken branch; ties keep the lower port index.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_BRANCH_PROVS; i++) begin
      if (IN_branches[i].taken &&
          !(state == RECOVER && !sqn_older(IN_branches[i].sqN, flush_sqn))) begin
        if (!found || sqn_older(IN_branches[i].sqN, winner.sqN)) begin
          winner = IN_branches[i];
          found  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      OUT_branch <= '0;
      state      <= IDLE;
      rec_cnt    <= '0;
      flush_sqn  <= '0;
    end else begin
      OUT_branch <= winner;
      if (found) begin
        flush_sqn <= winner.sqN;
        rec_cnt   <= REC_W'(RECOVERY_CYCLES - 1);
        state     <= RECOVER;
      end else if (state == RECOVER) begin
        if (rec_cnt == '0) state <= IDLE;
        else               rec_cnt <= rec_cnt - REC_W'(1);
      end
    end
  end

`ifdef BRANCH_RESOLVE_MISPRED_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                   OUT_mispredCnt <= '0;
    else if (OUT_branch.taken) OUT_mispredCnt <= OUT_mispredCnt + 32'(1);
  end
`endif

  BTUFifo #(
    .NUM_PUSH (NUM_BRANCH_PROVS),
    .DEPTH    (BTU_FIFO_DEPTH)
  ) u_btu_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_data (IN_btUpdates),
    .stall     (IN_btStall),
    .head_c    (OUT_btUpdate),
    .drop_cnt  (OUT_btDropCnt)
  );

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed scenarios plus randomized traffic against a behavioural model.
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  localparam int NB    = 2;
  localparam int DEPTH = 4;
  localparam int REC   = 2;

  logic        clk = 1'b0;
  logic        rst;
  BranchProv   br [NB];
  BTUpdate     bt [NB];
  logic        stall;
  BranchProv   out_br;
  BTUpdate     out_bt;
  logic [15:0] drop;
`ifdef BRANCH_RESOLVE_MISPRED_CNT_EN
  logic [31:0] mcnt;
`endif

  branch_resolve #(
    .NUM_BRANCH_PROVS (NB),
    .BTU_FIFO_DEPTH   (DEPTH),
    .RECOVERY_CYCLES  (REC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .IN_branches   (br),
    .IN_btUpdates  (bt),
    .IN_btStall    (stall),
    .OUT_branch    (out_br),
    .OUT_btUpdate  (out_bt),
    .OUT_btDropCnt (drop)
`ifdef BRANCH_RESOLVE_MISPRED_CNT_EN
    ,
    .OUT_mispredCnt(mcnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model state
  BTUpdate     q [$];
  int          rec_left;
  int          m_flush;
  logic        exp_taken;
  int          exp_sqn;
  logic [31:0] exp_pc;
  int          exp_drop;
  int          m_mcnt;
  int          tests;
  int          fails;

  function automatic bit older(int a, int b);
    return ((a - b) & 63) >= 32;
  endfunction

  function automatic BTUpdate mk_bt(int k);
    BTUpdate u;
    u.src    = 32'h1000 + 32'(k);
    u.dst    = 32'h2000 + 32'(k);
    u.isJump = (k % 2 == 1);
    u.valid  = 1'b1;
    return u;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Predict outputs after the coming edge from the inputs currently applied.
  task automatic model_step();
    int best;
    int d;
    if (rst) begin
      q.delete();
      rec_left  = 0;
      exp_taken = 1'b0;
      exp_drop  = 0;
      m_mcnt    = 0;
      return;
    end
    if (exp_taken) m_mcnt++;
    best = -1;
    for (int i = 0; i < NB; i++) begin
      if (br[i].taken && !(rec_left > 0 && !older(int'(br[i].sqN), m_flush))) begin
        if (best < 0 || older(int'(br[i].sqN), int'(br[best].sqN))) best = i;
      end
    end
    if (best >= 0) begin
      exp_taken = 1'b1;
      exp_sqn   = int'(br[best].sqN);
      exp_pc    = br[best].dstPC;
      m_flush   = exp_sqn;
      rec_left  = REC;
    end else begin
      exp_taken = 1'b0;
      if (rec_left > 0) rec_left--;
    end
    if (q.size() > 0 && !stall) void'(q.pop_front());
    d = 0;
    for (int i = 0; i < NB; i++) begin
      if (bt[i].valid) begin
        if (q.size() < DEPTH) q.push_back(bt[i]);
        else d++;
      end
    end
    exp_drop = (exp_drop + d > 65535) ? 65535 : exp_drop + d;
  endtask

  task automatic compare();
    check("br_taken", 64'(out_br.taken), 64'(exp_taken));
    if (exp_taken) begin
      check("br_sqn", 64'(out_br.sqN), 64'(exp_sqn));
      check("br_pc", 64'(out_br.dstPC), 64'(exp_pc));
    end
    check("bt_valid", 64'(out_bt.valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      check("bt_src", 64'(out_bt.src), 64'(q[0].src));
      check("bt_dst", 64'(out_bt.dst), 64'(q[0].dst));
      check("bt_jump", 64'(out_bt.isJump), 64'(q[0].isJump));
    end
    check("drop_cnt", 64'(drop), 64'(exp_drop));
`ifdef BRANCH_RESOLVE_MISPRED_CNT_EN
    check("mispred_cnt", 64'(mcnt), 64'(m_mcnt));
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic clr();
    for (int i = 0; i < NB; i++) begin
      br[i] = '0;
      bt[i] = '0;
    end
    stall = 1'b0;
  endtask

  task automatic set_br(input int p, input int sqn, input logic [31:0] pc);
    br[p].taken = 1'b1;
    br[p].sqN   = SqN'(sqn);
    br[p].dstPC = pc;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    exp_taken = 1'b0;
    rec_left  = 0;
    m_flush   = 0;
    exp_drop  = 0;
    m_mcnt    = 0;
    clr();
    rst = 1'b1;
    tick();
    tick();
    check("reset_taken", 64'(out_br.taken), 64'(0));
    check("reset_valid", 64'(out_bt.valid), 64'(0));
    check("reset_drop", 64'(drop), 64'(0));
    rst = 1'b0;
    tick();

    // Two taken in one cycle: older sqN wins
    clr(); set_br(0, 10, 32'hA0); set_br(1, 7, 32'hB0);
    tick();
    check("dir_oldest_sqn", 64'(out_br.sqN), 64'(7));
    check("dir_oldest_pc", 64'(out_br.dstPC), 64'(32'hB0));
    clr(); tick(); tick(); tick();

    // Wrap-around age compare
    set_br(0, 6'h3E, 32'hC0); set_br(1, 6'h01, 32'hD0);
    tick();
    check("dir_wrap_sqn", 64'(out_br.sqN), 64'(6'h3E));
    clr(); tick(); tick(); tick();

    // Recovery suppression and restart
    set_br(0, 20, 32'h20);
    tick();
    check("dir_flush20", 64'(out_br.sqN), 64'(20));
    clr(); set_br(0, 25, 32'h25);
    tick();
    check("dir_supp25", 64'(out_br.taken), 64'(0));
    clr(); set_br(1, 15, 32'h15);
    tick();
    check("dir_restart15_t", 64'(out_br.taken), 64'(1));
    check("dir_restart15_s", 64'(out_br.sqN), 64'(15));
    clr(); tick(); tick();
    set_br(0, 30, 32'h30);
    tick();
    check("dir_after30", 64'(out_br.sqN), 64'(30));
    clr();
    rst = 1'b1; tick(); rst = 1'b0;

    // Stalled queue fills and drops the excess
    stall = 1'b1;
    bt[0] = mk_bt(1); bt[1] = mk_bt(2); tick();
    bt[0] = mk_bt(3); bt[1] = mk_bt(4); tick();
    bt[0] = mk_bt(5); bt[1] = mk_bt(6); tick();
    check("dir_full_drop", 64'(drop), 64'(2));
    check("dir_full_head", 64'(out_bt.src), 64'(32'h1001));
    // Full queue, pop and push in the same cycle
    clr(); bt[0] = mk_bt(7);
    tick();
    check("dir_poppush_drop", 64'(drop), 64'(2));
    check("dir_poppush_head", 64'(out_bt.src), 64'(32'h1002));
    clr(); tick(); tick(); tick();
    check("dir_drain_head", 64'(out_bt.src), 64'(32'h1007));
    tick();
    check("dir_drain_empty", 64'(out_bt.valid), 64'(0));

    // Reset while in recovery with a non-empty queue
    set_br(0, 40, 32'h40); bt[0] = mk_bt(9);
    tick();
    set_br(0, 41, 32'h41); bt[0] = mk_bt(10); rst = 1'b1;
    tick();
    check("dir_rst_taken", 64'(out_br.taken), 64'(0));
    check("dir_rst_valid", 64'(out_bt.valid), 64'(0));
    check("dir_rst_drop", 64'(drop), 64'(0));
    rst = 1'b0; clr(); set_br(0, 45, 32'h45);
    tick();
    check("dir_rst_idle", 64'(out_br.sqN), 64'(45));

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NB; i++) begin
        br[i].taken  = ($urandom_range(0, 2) == 0);
        br[i].sqN    = SqN'($urandom);
        br[i].dstPC  = $urandom;
        bt[i].src    = $urandom;
        bt[i].dst    = $urandom;
        bt[i].isJump = 1'($urandom);
        bt[i].valid  = 1'($urandom);
      end
      stall = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter NUM_BRANCH_PROVS, default 2, number of ALU branch-provider ports.
REQ-002 SHALL have parameter BTU_FIFO_DEPTH, default 4, power of two, BT-update queue entries.
REQ-003 SHALL have parameter RECOVERY_CYCLES, default 2, cycles of younger-branch suppression after a flush.
REQ-004 Port list:
- clk  in  1  clock; one clock only.
- rst  in  1  reset; synchronous, active-high.
- IN_branches  in  BranchProv[NUM_BRANCH_PROVS]  per-ALU branch resolutions.
- IN_btUpdates  in  BTUpdate[NUM_BRANCH_PROVS]  per-ALU BTB update requests.
- IN_btStall  in  1  BTB write port busy this cycle.
- OUT_branch  out  BranchProv  selected flush; it also drives the ALUs' invalidate/invalidateSqN.
- OUT_btUpdate  out  BTUpdate  queue head to the BTB.
- OUT_btDropCnt  out  16  count of BT updates dropped because the queue was full.

Function
REQ-005 Candidates SHALL be IN_branches[i] with taken=1, minus those suppressed by REQ-009.
REQ-006 Selection SHALL pick the oldest candidate by signed sqN difference ($signed(a.sqN-b.sqN)<0 means a is older, wrap-safe); equal sqN SHALL go to the lower index.
REQ-007 OUT_branch SHALL be registered with 1-cycle latency: all fields of the winner, taken=1; with no winner, taken=0 and other fields don't-care.
REQ-008 FSM states: IDLE, RECOVER. A winner in any state SHALL load flushSqN←winner.sqN and recCnt←RECOVERY_CYCLES-1, and go to RECOVER.
REQ-009 In RECOVER, candidates with $signed(sqN-flushSqN)>=0 SHALL be suppressed; strictly older candidates SHALL still win and restart recovery.
REQ-010 In RECOVER with no winner, recCnt SHALL decrement; at recCnt==0 the state SHALL return to IDLE in the same cycle.
REQ-011 BT queue: each cycle, the valid IN_btUpdates SHALL be pushed in index order; pushes are limited to free = DEPTH-count+pop, so a same-cycle pop frees a slot.
REQ-012 Updates beyond the free slots SHALL be dropped from the highest index first, and OUT_btDropCnt SHALL increment by the drop count, saturating at 0xFFFF.
REQ-013 OUT_btUpdate SHALL be the queue head, with valid=1 only when the queue is non-empty; pop SHALL occur iff non-empty and !IN_btStall.
REQ-014 Push into an empty queue SHALL appear on OUT_btUpdate the next cycle; there is no bypass.
REQ-015 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.

Reset
REQ-016 On rst: OUT_branch.taken=0, OUT_btUpdate.valid=0, queue empty, pointers 0, state IDLE, recCnt 0, OUT_btDropCnt 0; other output fields don't-care.
REQ-017 rst SHALL override all same-cycle inputs: no push, pop or selection is recorded, including rst asserted mid-RECOVER or with the queue full.

Configuration
REQ-018 Macro BRANCH_RESOLVE_MISPRED_CNT_EN: when defined, output OUT_mispredCnt (32 bits) SHALL increment once per cycle OUT_branch.taken is set and reset to 0; when undefined, the port and counter SHALL be absent.

Structure
REQ-019 BranchProv, BTUpdate and SqN SHALL come from the shared package; the FSM state enum and RECOVERY_CYCLES default SHALL be added there.
REQ-020 The queue SHALL be a sub-module BTUFifo (multi-push, single-pop), instantiated once.

Verification
REQ-021 Two ports taken in the same cycle, sqN 10 and 7 -> next cycle OUT_branch.sqN=7, taken=1.
REQ-022 Port 0 taken with sqN 0x3E and port 1 taken with sqN 0x01 after wrap (6-bit SqN) -> 0x3E selected.
REQ-023 Flush of sqN 20, then sqN 25 taken next cycle -> suppressed (taken=0); sqN 15 taken next cycle -> selected and recovery restarted; after 2 idle cycles sqN 30 taken -> selected.
REQ-024 IN_btStall=1 with 2 pushes/cycle for 3 cycles (depth 4) -> 4 entries held, OUT_btDropCnt=2, head is the first push.
REQ-025 Queue full with IN_btStall=0 and 1 push -> the pop and push both occur, count stays 4, no drop.
REQ-026 rst for 1 cycle while RECOVER and queue non-empty -> next cycle state IDLE, OUT_btUpdate.valid=0, OUT_branch.taken=0.
